// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NREQ requesters.
// One op in flight; the registered result returns on a per-requester valid/ready channel.
module alu_arbiter #(
   parameter int NREQ = 2,
   parameter int DW   = 32,
   parameter int FW   = 4
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic [NREQ-1:0]           req_valid,
   output logic [NREQ-1:0]           req_ready,
   input  logic [NREQ-1:0][FW-1:0]   req_fun,
   input  logic [NREQ-1:0][DW-1:0]   req_op1,
   input  logic [NREQ-1:0][DW-1:0]   req_op2,
   output logic [NREQ-1:0]           rsp_valid,
   input  logic [NREQ-1:0]           rsp_ready,
   output logic [DW-1:0]             rsp_data,
   output logic [FW-1:0]             alu_fun,
   output logic [DW-1:0]             alu_op1,
   output logic [DW-1:0]             alu_op2,
   input  logic [DW-1:0]             alu_out
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic {IDLE, RESP} state_t;

   state_t        state;
   logic [PW-1:0] owner;
   logic [PW-1:0] ptr;
   logic [PW-1:0] scan;
   logic [PW-1:0] gnt_idx;
   logic [PW-1:0] sel;
   logic          gnt_any;
   logic          accept;
   logic          take;

   always_comb begin
      accept  = (state == IDLE) || rsp_ready[owner];
      gnt_any = 1'b0;
      gnt_idx = '0;
      scan    = '0;
      // first valid requester at or after the rr pointer, wrapping at NREQ
      for (int unsigned i = 0; i < NREQ; i++) begin
         scan = PW'((32'(ptr) + i) % NREQ);
         if (!gnt_any && req_valid[scan]) begin
            gnt_any = 1'b1;
            gnt_idx = scan;
         end
      end
      take = accept && gnt_any;

      req_ready = '0;
      if (take && resetn)
         req_ready[gnt_idx] = 1'b1;

      rsp_valid = '0;
      if (state == RESP)
         rsp_valid[owner] = 1'b1;

      sel     = take ? gnt_idx : '0;
      alu_fun = req_fun[sel];
      alu_op1 = req_op1[sel];
      alu_op2 = req_op2[sel];
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= IDLE;
         owner    <= '0;
         ptr      <= '0;
         rsp_data <= '0;
      end else if (take) begin
         state    <= RESP;
         owner    <= gnt_idx;
         rsp_data <= alu_out;
         ptr      <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      end else if (state == RESP && rsp_ready[owner]) begin
         state <= IDLE;
      end
   end

endmodule
